bster_cmd_mux: RTL and testbench
================================

// Module: bster_cmd_mux
// PURPOSE
//  N-channel front end for the BSTer core: round-robin arbitration of NB_CH AXI4-stream command
//  sources onto the single core cmd port. Routes each in-order completion (cpl) and status (sts)
//  back to the channel that issued the command. Sits between host/software agents and bster's
//  cmd/cpl/sts interfaces. Bster answers every command with exactly one cpl and one sts, in order.
// PARAMETERS
//  NB_CH      4    number of command channels (>=2)
//  CMD_WIDTH  128  command / completion payload width
//  STS_WIDTH  8    status payload width
//  TAG_DEPTH  8    max outstanding commands (power of 2, >=2); CH_W=$clog2(NB_CH) derived
// PORTS
//  aclk          in   1               clock
//  areset        in   1               asynchronous, active-high reset
//  s_cmd_tvalid  in   NB_CH           per-channel command valid
//  s_cmd_tready  out  NB_CH           per-channel command ready
//  s_cmd_tdata   in   NB_CH*CMD_WIDTH channel i at [i*CMD_WIDTH +: CMD_WIDTH]
//  m_cmd_tvalid  out  1               to bster cmd_tvalid
//  m_cmd_tready  in   1               from bster cmd_tready
//  m_cmd_tdata   out  CMD_WIDTH       to bster cmd_tdata
//  s_cpl_tvalid/tready/tdata  in/out/in  1/1/CMD_WIDTH  from bster cpl
//  s_sts_tvalid/tready/tdata  in/out/in  1/1/STS_WIDTH  from bster sts
//  m_cpl_tvalid/tready/tdata  out/in/out NB_CH/NB_CH/NB_CH*CMD_WIDTH  per-channel completions
//  m_sts_tvalid/tready/tdata  out/in/out NB_CH/NB_CH/NB_CH*STS_WIDTH  per-channel status
//  outstanding   out  $clog2(TAG_DEPTH)+1  commands issued, sts not yet delivered
//  err_unexp     out  1               sticky: cpl or sts arrived with no outstanding tag
// BEHAVIOUR
//  Reset: m_cmd_tvalid=0, m_cmd_tdata=0, s_cmd_tready=0, rr pointer=0, both tag FIFOs empty,
//   outstanding=0, err_unexp=0; m_cpl/m_sts valid=0 (derived from empty FIFOs).
//  Cmd stage: one output register. Arbiter runs when register empty or m_cmd_tready=1 (skid-free).
//   Also requires both tag FIFOs not full (registered flags). s_cmd_tready[g]=1 only for winner g.
//   Accept -> m_cmd_tvalid=1 next cycle (1-cycle latency); tdata stable while valid && !ready.
//  Round-robin: search starts at rr+1 mod NB_CH; after grant g, rr<=g. No request -> rr holds.
//  Tag FIFOs: cpl_fifo and sts_fifo, TAG_DEPTH x CH_W each, both push channel g on cmd accept.
//   Full: no push even if a pop occurs in the same cycle; push+pop when not full keeps level.
//  Return routing (combinational, 0 latency): h=head(cpl_fifo); m_cpl_tvalid[h]=s_cpl_tvalid,
//   other channels 0; data broadcast to slice h; s_cpl_tready=m_cpl_tready[h]; pop on handshake.
//   sts path identical with sts_fifo, independent of cpl (cpl and sts may be skewed).
//  Empty FIFO + s_cpl_tvalid (or sts): s_*_tready=1, beat dropped, err_unexp<=1 until reset.
//  outstanding: +1 on cmd accept, -1 on sts handshake; both same cycle -> unchanged.
//  Reset mid-operation clears all state; in-flight tags are lost (core is reset with it).
// CONFIGURATION
//  BSTER_CMD_MUX_PRIO_EN defined: fixed priority, channel 0 highest, rr pointer removed.
//   Undefined: round-robin as above. Tag FIFO and return routing identical in both builds.
// TESTING
//  1 Reset: areset=1 -> all valids 0, outstanding=0, err_unexp=0; release -> s_cmd_tready=0 idle.
//  2 RR: ch0..3 valid together, m_cmd_tready=1 -> core sees order 1,2,3,0 (rr=0 at reset);
//    PRIO_EN build -> 0,1,2,3.
//  3 Routing: cmds from ch2 then ch0; bster cpl 0xA then 0xB -> m_cpl[2]=0xA, m_cpl[0]=0xB;
//    sts 0x01,0x02 delayed 5 cycles -> m_sts[2]=0x01, m_sts[0]=0x02.
//  4 Full: 8 cmds accepted, no cpl/sts -> outstanding=8, all s_cmd_tready=0;
//    one sts+cpl -> next cmd accepted the cycle after.
//  5 Backpressure: m_cmd_tready=0 for 4 cycles -> m_cmd_tdata stable, no new s_cmd_tready;
//    m_cpl_tready[h]=0 -> s_cpl_tready=0.
//  6 Unexpected: s_sts_tvalid=1 with empty FIFO -> beat consumed, err_unexp=1, no m_sts valid.

Source files
------------

// File: rtl/bster_cmd_mux.sv
// bster_cmd_mux: arbitrates NB_CH AXI4-stream command channels onto the bster core and routes in-order cpl/sts beats back to the issuing channel.
// Build option: define BSTER_CMD_MUX_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.

module BsterTagFifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         i_push,
  input  logic [W-1:0] i_pushData,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic [CNT_W-1:0] w_countNext;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && (r_count != '0);
  assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      r_full  <= (w_countNext == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_empty = (r_count == '0);
  assign o_full  = r_full;
endmodule

module bster_cmd_mux #(
  parameter int NB_CH     = 4,
  parameter int CMD_WIDTH = 128,
  parameter int STS_WIDTH = 8,
  parameter int TAG_DEPTH = 8,
  localparam int CH_W     = $clog2(NB_CH),
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NB_CH-1:0]           s_cmd_tvalid,
  output logic [NB_CH-1:0]           s_cmd_tready,
  input  logic [NB_CH*CMD_WIDTH-1:0] s_cmd_tdata,
  output logic                       m_cmd_tvalid,
  input  logic                       m_cmd_tready,
  output logic [CMD_WIDTH-1:0]       m_cmd_tdata,
  input  logic                       s_cpl_tvalid,
  output logic                       s_cpl_tready,
  input  logic [CMD_WIDTH-1:0]       s_cpl_tdata,
  input  logic                       s_sts_tvalid,
  output logic                       s_sts_tready,
  input  logic [STS_WIDTH-1:0]       s_sts_tdata,
  output logic [NB_CH-1:0]           m_cpl_tvalid,
  input  logic [NB_CH-1:0]           m_cpl_tready,
  output logic [NB_CH*CMD_WIDTH-1:0] m_cpl_tdata,
  output logic [NB_CH-1:0]           m_sts_tvalid,
  input  logic [NB_CH-1:0]           m_sts_tready,
  output logic [NB_CH*STS_WIDTH-1:0] m_sts_tdata,
  output logic [CNT_W-1:0]           outstanding,
  output logic                       err_unexp
);
  logic [CMD_WIDTH-1:0] w_chData [NB_CH];
  logic                 r_cmdValid;
  logic [CMD_WIDTH-1:0] r_cmdData;
  logic [CNT_W-1:0]     r_outstanding;
  logic                 r_errUnexp;
  logic                 w_arbEn;
  logic                 w_found;
  logic [CH_W-1:0]      w_grant;
  logic                 w_accept;
  logic [CH_W-1:0]      w_cplHead;
  logic [CH_W-1:0]      w_stsHead;
  logic                 w_cplEmpty;
  logic                 w_stsEmpty;
  logic                 w_cplFull;
  logic                 w_stsFull;
  logic                 w_cplPop;
  logic                 w_stsPop;

  // Arbitration only when the output register can take a beat and both tag FIFOs have room.
  assign w_arbEn  = (!r_cmdValid || m_cmd_tready) && !w_cplFull && !w_stsFull;
  assign w_accept = w_arbEn && w_found;
  assign s_cmd_tready = w_accept ? (NB_CH'(1) << w_grant) : '0;

`ifdef BSTER_CMD_MUX_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      if (s_cmd_tvalid[i]) begin
        w_found = 1'b1;
        w_grant = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W-1:0] r_rr;
  int              w_idx;
  logic [CH_W-1:0] w_sel;

  // Walk offsets from farthest to nearest so the channel just after r_rr wins last.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    w_sel   = '0;
    for (int i = NB_CH; i >= 1; i--) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NB_CH) w_idx = w_idx - NB_CH;
      w_sel = CH_W'(w_idx);
      if (s_cmd_tvalid[w_sel]) begin
        w_found = 1'b1;
        w_grant = w_sel;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)        r_rr <= '0;
    else if (w_accept) r_rr <= w_grant;
  end
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cmdValid <= 1'b0;
      r_cmdData  <= '0;
    end else if (w_accept) begin
      r_cmdValid <= 1'b1;
      r_cmdData  <= w_chData[w_grant];
    end else if (m_cmd_tready) begin
      r_cmdValid <= 1'b0;
    end
  end

  assign m_cmd_tvalid = r_cmdValid;
  assign m_cmd_tdata  = r_cmdData;

  BsterTagFifo #(.DEPTH(TAG_DEPTH), .W(CH_W)) u_cplFifo (
    .aclk       (aclk),
    .areset     (areset),
    .i_push     (w_accept),
    .i_pushData (w_grant),
    .i_pop      (w_cplPop),
    .o_head     (w_cplHead),
    .o_empty    (w_cplEmpty),
    .o_full     (w_cplFull)
  );

  BsterTagFifo #(.DEPTH(TAG_DEPTH), .W(CH_W)) u_stsFifo (
    .aclk       (aclk),
    .areset     (areset),
    .i_push     (w_accept),
    .i_pushData (w_grant),
    .i_pop      (w_stsPop),
    .o_head     (w_stsHead),
    .o_empty    (w_stsEmpty),
    .o_full     (w_stsFull)
  );

  // With no tag outstanding the beat is swallowed so the core never stalls on it.
  assign s_cpl_tready = w_cplEmpty ? 1'b1 : m_cpl_tready[w_cplHead];
  assign s_sts_tready = w_stsEmpty ? 1'b1 : m_sts_tready[w_stsHead];
  assign w_cplPop     = s_cpl_tvalid && !w_cplEmpty && m_cpl_tready[w_cplHead];
  assign w_stsPop     = s_sts_tvalid && !w_stsEmpty && m_sts_tready[w_stsHead];

  for (genvar gc = 0; gc < NB_CH; gc++) begin : g_ch
    logic w_cplSel;
    logic w_stsSel;
    assign w_chData[gc] = s_cmd_tdata[gc*CMD_WIDTH +: CMD_WIDTH];
    assign w_cplSel     = !w_cplEmpty && (w_cplHead == CH_W'(gc));
    assign w_stsSel     = !w_stsEmpty && (w_stsHead == CH_W'(gc));
    assign m_cpl_tvalid[gc] = w_cplSel && s_cpl_tvalid;
    assign m_sts_tvalid[gc] = w_stsSel && s_sts_tvalid;
    assign m_cpl_tdata[gc*CMD_WIDTH +: CMD_WIDTH] = w_cplSel ? s_cpl_tdata : '0;
    assign m_sts_tdata[gc*STS_WIDTH +: STS_WIDTH] = w_stsSel ? s_sts_tdata : '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_outstanding <= '0;
      r_errUnexp    <= 1'b0;
    end else begin
      if (w_accept && !w_stsPop)      r_outstanding <= r_outstanding + 1'b1;
      else if (!w_accept && w_stsPop) r_outstanding <= r_outstanding - 1'b1;
      if ((w_cplEmpty && s_cpl_tvalid) || (w_stsEmpty && s_sts_tvalid)) r_errUnexp <= 1'b1;
    end
  end

  assign outstanding = r_outstanding;
  assign err_unexp   = r_errUnexp;
endmodule

// File: tb/tb_bster_cmd_mux.sv
// Testbench for bster_cmd_mux: directed scenarios plus randomized traffic against a queue-based reference model.
// Builds with or without BSTER_CMD_MUX_PRIO_EN; expected grant order follows the same macro.

module tb_bster_cmd_mux;
  localparam int NB_CH     = 4;
  localparam int CMD_WIDTH = 128;
  localparam int STS_WIDTH = 8;
  localparam int TAG_DEPTH = 8;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

  logic                       aclk = 1'b0;
  logic                       areset = 1'b1;
  logic [NB_CH-1:0]           s_cmd_tvalid = '0;
  logic [NB_CH-1:0]           s_cmd_tready;
  logic [NB_CH*CMD_WIDTH-1:0] s_cmd_tdata = '0;
  logic                       m_cmd_tvalid;
  logic                       m_cmd_tready = 1'b0;
  logic [CMD_WIDTH-1:0]       m_cmd_tdata;
  logic                       s_cpl_tvalid = 1'b0;
  logic                       s_cpl_tready;
  logic [CMD_WIDTH-1:0]       s_cpl_tdata = '0;
  logic                       s_sts_tvalid = 1'b0;
  logic                       s_sts_tready;
  logic [STS_WIDTH-1:0]       s_sts_tdata = '0;
  logic [NB_CH-1:0]           m_cpl_tvalid;
  logic [NB_CH-1:0]           m_cpl_tready = '0;
  logic [NB_CH*CMD_WIDTH-1:0] m_cpl_tdata;
  logic [NB_CH-1:0]           m_sts_tvalid;
  logic [NB_CH-1:0]           m_sts_tready = '0;
  logic [NB_CH*STS_WIDTH-1:0] m_sts_tdata;
  logic [CNT_W-1:0]           outstanding;
  logic                       err_unexp;

  always #5 aclk = ~aclk;

  bster_cmd_mux #(
    .NB_CH(NB_CH), .CMD_WIDTH(CMD_WIDTH), .STS_WIDTH(STS_WIDTH), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready), .s_cmd_tdata(s_cmd_tdata),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
    .s_cpl_tvalid(s_cpl_tvalid), .s_cpl_tready(s_cpl_tready), .s_cpl_tdata(s_cpl_tdata),
    .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready), .s_sts_tdata(s_sts_tdata),
    .m_cpl_tvalid(m_cpl_tvalid), .m_cpl_tready(m_cpl_tready), .m_cpl_tdata(m_cpl_tdata),
    .m_sts_tvalid(m_sts_tvalid), .m_sts_tready(m_sts_tready), .m_sts_tdata(m_sts_tdata),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [CMD_WIDTH-1:0] got, input logic [CMD_WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: every command is a tag queued for its cpl and its sts; the head tag names the return channel.
  logic                 mCmdV;
  logic [CMD_WIDTH-1:0] mCmdD;
  int                   lastGrant;
  int                   mOut;
  logic                 mErr;
  int                   cplQ[$];
  int                   stsQ[$];
  logic                 mCanArb;
  int                   mG;
  int                   mH;
  logic [NB_CH-1:0]     expRdy;
  logic [NB_CH-1:0]     expV;
  logic                 expCplRdy;
  logic                 expStsRdy;

  always begin
    @(negedge aclk);
    if (areset) begin
      mCmdV = 1'b0; mCmdD = '0; lastGrant = 0; mOut = 0; mErr = 1'b0;
      cplQ.delete(); stsQ.delete();
      checkOutput("rst_cmd_valid", CMD_WIDTH'(m_cmd_tvalid), '0);
      checkOutput("rst_cmd_ready", CMD_WIDTH'(s_cmd_tready), '0);
      checkOutput("rst_outstanding", CMD_WIDTH'(outstanding), '0);
      checkOutput("rst_err", CMD_WIDTH'(err_unexp), '0);
    end else begin
      mCanArb = (!mCmdV || m_cmd_tready) && (cplQ.size() < TAG_DEPTH) && (stsQ.size() < TAG_DEPTH);
      mG = -1;
      if (mCanArb) begin
`ifdef BSTER_CMD_MUX_PRIO_EN
        for (int k = 0; k < NB_CH; k++)
          if (mG < 0 && s_cmd_tvalid[k]) mG = k;
`else
        for (int k = 1; k <= NB_CH; k++)
          if (mG < 0 && s_cmd_tvalid[(lastGrant + k) % NB_CH]) mG = (lastGrant + k) % NB_CH;
`endif
      end
      expRdy = '0;
      if (mG >= 0) expRdy[mG] = 1'b1;
      checkOutput("cmd_ready", CMD_WIDTH'(s_cmd_tready), CMD_WIDTH'(expRdy));
      checkOutput("cmd_valid", CMD_WIDTH'(m_cmd_tvalid), CMD_WIDTH'(mCmdV));
      checkOutput("cmd_data", m_cmd_tdata, mCmdD);

      expV = '0; expCplRdy = 1'b1;
      if (cplQ.size() > 0) begin
        mH = cplQ[0];
        expV[mH] = s_cpl_tvalid;
        expCplRdy = m_cpl_tready[mH];
        if (s_cpl_tvalid) checkOutput("cpl_data", m_cpl_tdata[mH*CMD_WIDTH +: CMD_WIDTH], s_cpl_tdata);
      end
      checkOutput("cpl_valid", CMD_WIDTH'(m_cpl_tvalid), CMD_WIDTH'(expV));
      checkOutput("cpl_ready", CMD_WIDTH'(s_cpl_tready), CMD_WIDTH'(expCplRdy));

      expV = '0; expStsRdy = 1'b1;
      if (stsQ.size() > 0) begin
        mH = stsQ[0];
        expV[mH] = s_sts_tvalid;
        expStsRdy = m_sts_tready[mH];
        if (s_sts_tvalid)
          checkOutput("sts_data", CMD_WIDTH'(m_sts_tdata[mH*STS_WIDTH +: STS_WIDTH]), CMD_WIDTH'(s_sts_tdata));
      end
      checkOutput("sts_valid", CMD_WIDTH'(m_sts_tvalid), CMD_WIDTH'(expV));
      checkOutput("sts_ready", CMD_WIDTH'(s_sts_tready), CMD_WIDTH'(expStsRdy));
      checkOutput("outstanding", CMD_WIDTH'(outstanding), CMD_WIDTH'(mOut));
      checkOutput("err_unexp", CMD_WIDTH'(err_unexp), CMD_WIDTH'(mErr));

      if (s_cpl_tvalid && expCplRdy) begin
        if (cplQ.size() == 0) mErr = 1'b1;
        else void'(cplQ.pop_front());
      end
      if (s_sts_tvalid && expStsRdy) begin
        if (stsQ.size() == 0) mErr = 1'b1;
        else begin
          void'(stsQ.pop_front());
          mOut--;
        end
      end
      if (mG >= 0) begin
        cplQ.push_back(mG);
        stsQ.push_back(mG);
        mCmdV = 1'b1;
        mCmdD = s_cmd_tdata[mG*CMD_WIDTH +: CMD_WIDTH];
        lastGrant = mG;
        mOut++;
      end else if (m_cmd_tready) begin
        mCmdV = 1'b0;
      end
    end
  end

  // Stimulus-side bookkeeping for the directed scenarios.
  int                   accCnt;
  int                   cplSent;
  int                   stsSent;
  logic [7:0]           coreSeen[$];
  logic [CMD_WIDTH-1:0] lastCmdData [NB_CH];

  task automatic stepCycle();
    logic [NB_CH-1:0] acc;
    logic cplHs, stsHs, inRst;
    @(negedge aclk);
    inRst = areset;
    acc   = s_cmd_tvalid & s_cmd_tready;
    cplHs = s_cpl_tvalid && s_cpl_tready;
    stsHs = s_sts_tvalid && s_sts_tready;
    if (m_cmd_tvalid && m_cmd_tready && !inRst) coreSeen.push_back(m_cmd_tdata[7:0]);
    @(posedge aclk);
    #1;
    if (!inRst) begin
      accCnt += $countones(acc);
      if (cplHs) cplSent++;
      if (stsHs) stsSent++;
    end
    s_cmd_tvalid = s_cmd_tvalid & ~acc;
    if (cplHs) s_cpl_tvalid = 1'b0;
    if (stsHs) s_sts_tvalid = 1'b0;
  endtask

  task automatic raiseCmd(input int c);
    logic [CMD_WIDTH-1:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    d[7:0] = 8'(c);
    s_cmd_tdata[c*CMD_WIDTH +: CMD_WIDTH] = d;
    s_cmd_tvalid[c] = 1'b1;
    lastCmdData[c] = d;
  endtask

  task automatic resetDut();
    areset = 1'b1;
    s_cmd_tvalid = '0; s_cpl_tvalid = 1'b0; s_sts_tvalid = 1'b0;
    m_cmd_tready = 1'b0; m_cpl_tready = '0; m_sts_tready = '0;
    repeat (2) stepCycle();
    areset = 1'b0;
    accCnt = 0; cplSent = 0; stsSent = 0;
    coreSeen.delete();
  endtask

  task automatic drainAll(input string name);
    m_cmd_tready = 1'b1; m_cpl_tready = '1; m_sts_tready = '1;
    for (int n = 0; n < 300 && (s_cmd_tvalid != '0 || cplSent != accCnt || stsSent != accCnt); n++) begin
      if (!s_cpl_tvalid && cplSent < accCnt) begin
        s_cpl_tvalid = 1'b1; s_cpl_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!s_sts_tvalid && stsSent < accCnt) begin
        s_sts_tvalid = 1'b1; s_sts_tdata = 8'($urandom());
      end
      stepCycle();
    end
    checkOutput({name, "_drained"}, CMD_WIDTH'(cplSent == accCnt && stsSent == accCnt), CMD_WIDTH'(1));
    #1 checkOutput({name, "_outstanding_zero"}, CMD_WIDTH'(outstanding), '0);
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < NB_CH; c++)
      if (!s_cmd_tvalid[c] && $urandom_range(0, 2) == 0) raiseCmd(c);
    m_cmd_tready = ($urandom_range(0, 3) != 0);
    if (!s_cpl_tvalid && cplSent < accCnt && $urandom_range(0, 1) == 0) begin
      s_cpl_tvalid = 1'b1; s_cpl_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    if (!s_sts_tvalid && stsSent < accCnt && $urandom_range(0, 2) == 0) begin
      s_sts_tvalid = 1'b1; s_sts_tdata = 8'($urandom());
    end
    m_cpl_tready = NB_CH'($urandom());
    m_sts_tready = NB_CH'($urandom());
  endtask

  int expOrder [NB_CH];

  initial begin
`ifdef BSTER_CMD_MUX_PRIO_EN
    expOrder = '{0, 1, 2, 3};
`else
    expOrder = '{1, 2, 3, 0};
`endif
    accCnt = 0; cplSent = 0; stsSent = 0;

    // Reset state, then idle after release
    stepCycle();
    checkOutput("t1_rst_cmd_valid", CMD_WIDTH'(m_cmd_tvalid), '0);
    checkOutput("t1_rst_outstanding", CMD_WIDTH'(outstanding), '0);
    checkOutput("t1_rst_err", CMD_WIDTH'(err_unexp), '0);
    checkOutput("t1_rst_cpl_valid", CMD_WIDTH'(m_cpl_tvalid), '0);
    checkOutput("t1_rst_sts_valid", CMD_WIDTH'(m_sts_tvalid), '0);
    areset = 1'b0;
    stepCycle();
    #1 checkOutput("t1_idle_cmd_ready", CMD_WIDTH'(s_cmd_tready), '0);

    // Unexpected sts with no tag outstanding
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h55;
    #1;
    checkOutput("t6_sts_ready", CMD_WIDTH'(s_sts_tready), CMD_WIDTH'(1));
    checkOutput("t6_msts_valid", CMD_WIDTH'(m_sts_tvalid), '0);
    stepCycle();
    #1 checkOutput("t6_err_set", CMD_WIDTH'(err_unexp), CMD_WIDTH'(1));
    resetDut();
    #1 checkOutput("t6_err_cleared", CMD_WIDTH'(err_unexp), '0);

    // Grant order with all channels requesting
    m_cmd_tready = 1'b1;
    for (int c = 0; c < NB_CH; c++) raiseCmd(c);
    for (int n = 0; n < 20 && coreSeen.size() < NB_CH; n++) stepCycle();
    for (int k = 0; k < NB_CH; k++)
      checkOutput($sformatf("t2_order%0d", k),
                  CMD_WIDTH'((coreSeen.size() > k) ? coreSeen[k] : 8'hFF), CMD_WIDTH'(expOrder[k]));
    drainAll("t2");

    // Return routing: ch2 then ch0
    resetDut();
    m_cmd_tready = 1'b1;
    raiseCmd(2);
    for (int n = 0; n < 10 && accCnt < 1; n++) stepCycle();
    raiseCmd(0);
    for (int n = 0; n < 10 && accCnt < 2; n++) stepCycle();
    checkOutput("t3_two_accepted", CMD_WIDTH'(accCnt), CMD_WIDTH'(2));
    m_cpl_tready = '1; m_sts_tready = '1;
    s_cpl_tvalid = 1'b1; s_cpl_tdata = CMD_WIDTH'(32'hA);
    #1;
    checkOutput("t3_cpl_valid_a", CMD_WIDTH'(m_cpl_tvalid), CMD_WIDTH'(4'b0100));
    checkOutput("t3_cpl_data_a", m_cpl_tdata[2*CMD_WIDTH +: CMD_WIDTH], CMD_WIDTH'(32'hA));
    stepCycle();
    s_cpl_tvalid = 1'b1; s_cpl_tdata = CMD_WIDTH'(32'hB);
    #1;
    checkOutput("t3_cpl_valid_b", CMD_WIDTH'(m_cpl_tvalid), CMD_WIDTH'(4'b0001));
    checkOutput("t3_cpl_data_b", m_cpl_tdata[0 +: CMD_WIDTH], CMD_WIDTH'(32'hB));
    stepCycle();
    repeat (5) stepCycle();
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h01;
    #1;
    checkOutput("t3_sts_valid_1", CMD_WIDTH'(m_sts_tvalid), CMD_WIDTH'(4'b0100));
    checkOutput("t3_sts_data_1", CMD_WIDTH'(m_sts_tdata[2*STS_WIDTH +: STS_WIDTH]), CMD_WIDTH'(8'h01));
    stepCycle();
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h02;
    #1;
    checkOutput("t3_sts_valid_2", CMD_WIDTH'(m_sts_tvalid), CMD_WIDTH'(4'b0001));
    checkOutput("t3_sts_data_2", CMD_WIDTH'(m_sts_tdata[0 +: STS_WIDTH]), CMD_WIDTH'(8'h02));
    stepCycle();
    #1 checkOutput("t3_outstanding_zero", CMD_WIDTH'(outstanding), '0);

    // Tag FIFOs full
    resetDut();
    m_cmd_tready = 1'b1;
    for (int n = 0; n < 40 && accCnt < TAG_DEPTH; n++) begin
      if (!s_cmd_tvalid[3]) raiseCmd(3);
      stepCycle();
    end
    if (!s_cmd_tvalid[3]) raiseCmd(3);
    repeat (2) stepCycle();
    #1;
    checkOutput("t4_outstanding_full", CMD_WIDTH'(outstanding), CMD_WIDTH'(TAG_DEPTH));
    checkOutput("t4_ready_blocked", CMD_WIDTH'(s_cmd_tready), '0);
    m_cpl_tready = '1; m_sts_tready = '1;
    s_cpl_tvalid = 1'b1; s_cpl_tdata = CMD_WIDTH'(32'h77);
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h33;
    #1 checkOutput("t4_ready_during_pop", CMD_WIDTH'(s_cmd_tready), '0);
    stepCycle();
    #1 checkOutput("t4_ready_after_pop", CMD_WIDTH'(s_cmd_tready), CMD_WIDTH'(4'b1000));
    stepCycle();
    #1 checkOutput("t4_outstanding_refill", CMD_WIDTH'(outstanding), CMD_WIDTH'(TAG_DEPTH));
    drainAll("t4");

    // Backpressure on the core and on a return channel
    resetDut();
    m_cmd_tready = 1'b0;
    raiseCmd(1);
    stepCycle();
    raiseCmd(2);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("t5_data_hold", m_cmd_tdata, lastCmdData[1]);
      checkOutput("t5_no_ready", CMD_WIDTH'(s_cmd_tready), '0);
      stepCycle();
    end
    m_cpl_tready = 4'b1101;
    s_cpl_tvalid = 1'b1; s_cpl_tdata = CMD_WIDTH'(32'h5A);
    #1;
    checkOutput("t5_cpl_ready_low", CMD_WIDTH'(s_cpl_tready), '0);
    checkOutput("t5_cpl_valid", CMD_WIDTH'(m_cpl_tvalid), CMD_WIDTH'(4'b0010));
    stepCycle();
    drainAll("t5");

    // Randomized traffic with a mid-run reset
    resetDut();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) resetDut();
      applyStimulus();
      stepCycle();
    end
    drainAll("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
